// File: rtl/alu_frame_deserializer.sv
// ---------------------------------------------------------------------------
// alu_frame_deserializer
//
// Serial front end of the ALU datapath. Deframes 12-bit packets from the
// one-bit line `sin` (start, type, payload[7:0] MSB first, even parity,
// stop). DATA payloads are stacked; each CONTROL payload produces one
// command bundle carrying the two most recent stacked bytes and a status
// code. The stack and both sticky error flags are cleared on every CONTROL.
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   sin          in   serial line, idles high, one bit per clock
//   out_valid    out  one-cycle pulse while a bundle is presented
//   out_cmd      out  received command byte (operation_t encoding)
//   out_arg_a    out  second-most-recent stacked byte, 0 if missing
//   out_arg_b    out  most recent stacked byte, 0 if missing
//   out_status   out  status_t code qualifying the bundle
//   stack_level  out  number of stacked bytes, saturates at DATA_DEPTH
//   dbg_state    out  current deframer state (state_t encoding)
//
// Handshake: out_valid has no ready. The bundle is presented for exactly
// one cycle; the consumer must take it then. The bundle fields hold until
// the next bundle, only out_valid drops.
// ---------------------------------------------------------------------------
module alu_frame_deserializer #(
  parameter int DATA_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       out_valid,
  output logic [7:0] out_cmd,
  output logic [7:0] out_arg_a,
  output logic [7:0] out_arg_b,
  output logic [7:0] out_status,
  output logic [3:0] stack_level,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_STOP   = 3'd2,
    ST_DONE   = 3'd3,
    ST_RESYNC = 3'd4
  } state_t;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_AND = 8'h01,
    OP_OR  = 8'h02,
    OP_XOR = 8'h03,
    OP_ADD = 8'h10,
    OP_SUB = 8'h20
  } operation_t;

  typedef enum logic [7:0] {
    S_NO_ERROR             = 8'h00,
    S_MISSING_DATA         = 8'h01,
    S_DATA_STACK_OVERFLOW  = 8'h02,
    S_DATA_PARITY_ERROR    = 8'h20,
    S_COMMAND_PARITY_ERROR = 8'h40,
    S_INVALID_COMMAND      = 8'h80
  } status_t;

  localparam logic [3:0] DEPTH_L = 4'(DATA_DEPTH);

  // Deframer state
  state_t      state_q;
  logic [9:0]  shift_q;   // {type, payload[7:0], parity} once full
  logic [3:0]  cnt_q;     // bits shifted so far in SHIFT

  // Operand stack. Sixteen entries keep the 4-bit level a legal index for
  // every DATA_DEPTH in 2..15; entries at or above DATA_DEPTH are never
  // written.
  logic [7:0]  stack_q [16];
  logic [3:0]  level_q;
  logic        dpar_q;    // sticky: a DATA frame had bad parity
  logic        ovf_q;     // sticky: a good DATA byte hit a full stack

  // Registered bundle
  logic        valid_q;
  logic [7:0]  cmd_q;
  logic [7:0]  arg_a_q;
  logic [7:0]  arg_b_q;
  logic [7:0]  status_q;

  // Decoded view of the frame currently held in shift_q
  logic        frame_type;
  logic [7:0]  frame_payload;
  logic        frame_par_ok;
  logic        cmd_known;

  // Next bundle values, captured on the STOP edge of a CONTROL frame
  logic [7:0]  arg_a_d;
  logic [7:0]  arg_b_d;
  logic [7:0]  status_d;

  assign frame_type    = shift_q[9];
  assign frame_payload = shift_q[8:1];
  // Even parity: the ten bits type+payload+parity must XOR to zero.
  assign frame_par_ok  = ~(^shift_q);

  always_comb begin
    cmd_known = 1'b0;
    case (frame_payload)
      OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: cmd_known = 1'b1;
      default:                                       cmd_known = 1'b0;
    endcase
  end

  always_comb begin
    arg_a_d = 8'h00;
    arg_b_d = 8'h00;
    if (level_q >= 4'd1) arg_b_d = stack_q[level_q - 4'd1];
    if (level_q >= 4'd2) arg_a_d = stack_q[level_q - 4'd2];
  end

  // Status priority: the first matching condition wins.
  always_comb begin
    status_d = S_NO_ERROR;
    if (!frame_par_ok)
      status_d = S_COMMAND_PARITY_ERROR;
    else if (dpar_q)
      status_d = S_DATA_PARITY_ERROR;
    else if (!cmd_known)
      status_d = S_INVALID_COMMAND;
    else if (ovf_q)
      status_d = S_DATA_STACK_OVERFLOW;
    else if (frame_payload != OP_NOP && level_q < 4'd2)
      status_d = S_MISSING_DATA;
  end

  // Bundle outputs are loaded on the edge that accepts the stop bit so they
  // are valid throughout the DONE cycle. The stack update for the same
  // frame happens on the edge that leaves DONE, so the bundle always sees
  // the stack as it was before the CONTROL frame cleared it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      dpar_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      status_q <= S_NO_ERROR;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!sin) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_q <= {shift_q[8:0], sin};
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (sin) begin
            state_q <= ST_DONE;
            if (frame_type) begin
              valid_q  <= 1'b1;
              cmd_q    <= frame_payload;
              arg_a_q  <= arg_a_d;
              arg_b_q  <= arg_b_d;
              status_q <= status_d;
            end
          end else begin
            // Framing error: drop the frame, wait for the line to idle.
            state_q <= ST_RESYNC;
          end
        end
        ST_DONE: begin
          // sin is deliberately ignored here; a start bit is only
          // recognised once back in IDLE.
          state_q <= ST_IDLE;
          if (frame_type) begin
            level_q <= '0;
            dpar_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end else if (!frame_par_ok) begin
            dpar_q <= 1'b1;
          end else if (level_q < DEPTH_L) begin
            stack_q[level_q] <= frame_payload;
            level_q          <= level_q + 4'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        ST_RESYNC: begin
          if (sin) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = valid_q;
  assign out_cmd     = cmd_q;
  assign out_arg_a   = arg_a_q;
  assign out_arg_b   = arg_b_q;
  assign out_status  = status_q;
  assign stack_level = level_q;
  assign dbg_state   = state_q;

endmodule
